// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the shared ALU
// one addu/subu per granted cycle (shift-add multiply, restoring divide).
module alu_muldiv_seq #(
  parameter logic [3:0] ALUCTRL_ADDU = 4'b0110,
  parameter logic [3:0] ALUCTRL_SUBU = 4'b0111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [31:0] alu_r1,
  output logic [31:0] alu_r2,
  output logic [3:0]  alu_aluctrl,
  output logic        alu_alui,
  input  logic [31:0] alu_out,
  input  logic        alu_lt
);

  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 6;
  localparam logic [CW-1:0] LAST = CW'(31);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t        state, state_next;
  logic [1:0]    op_q, op_next;
  // acc holds hi (multiply) or rem (divide); lo_q holds lo or quo; opnd holds mc or dvs
  logic [W-1:0]  acc, acc_next;
  logic [W-1:0]  lo_q, lo_next;
  logic [W-1:0]  opnd, opnd_next;
  logic [CW-1:0] count, count_next;
  logic [W-1:0]  result_next;
  logic [W-1:0]  sh;
  logic          carry;
  logic          is_div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= 2'b00;
      acc    <= '0;
      lo_q   <= '0;
      opnd   <= '0;
      count  <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      op_q   <= op_next;
      acc    <= acc_next;
      lo_q   <= lo_next;
      opnd   <= opnd_next;
      count  <= count_next;
      result <= result_next;
      busy   <= (state_next == EXEC);
      done   <= (state_next == DONE);
    end
  end

  assign alu_req = busy;

  always_comb begin
    state_next  = state;
    op_next     = op_q;
    acc_next    = acc;
    lo_next     = lo_q;
    opnd_next   = opnd;
    count_next  = count;
    result_next = result;
    alu_r1      = '0;
    alu_r2      = '0;
    alu_aluctrl = 4'b0000;
    alu_alui    = 1'b0;
    is_div      = op_q[1];
    sh          = {acc[W-2:0], lo_q[W-1]};
    carry       = (alu_out < acc);

    // ALU operands are presented for the whole of EXEC, stalled or not
    if (state == EXEC) begin
      if (is_div) begin
        alu_r1      = sh;
        alu_r2      = opnd;
        alu_aluctrl = ALUCTRL_SUBU;
      end else begin
        alu_r1      = acc;
        alu_r2      = lo_q[0] ? opnd : '0;
        alu_aluctrl = ALUCTRL_ADDU;
      end
    end

    case (state)
      IDLE: begin
        if (start && !flush) begin
          op_next    = op;
          acc_next   = '0;
          count_next = '0;
          if (op[1]) begin
            lo_next   = opa;
            opnd_next = opb;
          end else begin
            lo_next   = opb;
            opnd_next = opa;
          end
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (flush) begin
          state_next = IDLE;
        end else if (alu_gnt) begin
          if (is_div) begin
            // rem[31] set means the shifted value exceeds 32 bits, so it always fits dvs
            if (acc[W-1] || !alu_lt) begin
              acc_next = alu_out;
              lo_next  = {lo_q[W-2:0], 1'b1};
            end else begin
              acc_next = sh;
              lo_next  = {lo_q[W-2:0], 1'b0};
            end
          end else begin
            acc_next = {carry, alu_out[W-1:1]};
            lo_next  = {alu_out[0], lo_q[W-1:1]};
          end
          count_next = count + CW'(1);
          if (count == LAST) begin
            state_next  = DONE;
            // MULHU/REMU take the upper register, MUL/DIVU the lower
            result_next = op_q[0] ? acc_next : lo_next;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: behavioural shared ALU, directed and random ops
// checked against plain 64-bit arithmetic.
module tb_alu_muldiv_seq;

  localparam logic [3:0] ADDU = 4'b0110;
  localparam logic [3:0] SUBU = 4'b0111;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa, opb;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;
  logic        alu_req, alu_gnt;
  logic [31:0] alu_r1, alu_r2;
  logic [3:0]  alu_aluctrl;
  logic        alu_alui;
  logic [31:0] alu_out;
  logic        alu_lt;

  logic [31:0] junk;
  logic [31:0] r1m, r2m;
  logic [3:0]  ctrlm;

  int n_cmp = 0;
  int n_err = 0;

  alu_muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .flush(flush), .busy(busy), .done(done), .result(result),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_r1(alu_r1), .alu_r2(alu_r2),
    .alu_aluctrl(alu_aluctrl), .alu_alui(alu_alui), .alu_out(alu_out),
    .alu_lt(alu_lt)
  );

  always #5 clk = ~clk;

  // Shared ALU; when not granted the CPU owns its inputs (modelled as junk)
  always_comb begin
    r1m     = alu_gnt ? alu_r1 : junk;
    r2m     = alu_gnt ? alu_r2 : ~junk;
    ctrlm   = alu_gnt ? alu_aluctrl : ADDU;
    alu_out = (ctrlm == SUBU) ? (r1m - r2m) : (r1m + r2m);
    alu_lt  = (r1m < r2m);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic accept(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; alu_gnt = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // mode 0: gnt always 1, 1: toggling 1,0,1,..., 2: random; poke issues a stray start mid-op
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int mode, input bit poke);
    logic [31:0] exp;
    logic [31:0] held;
    int grants;
    int edge_due;
    int e;
    exp = ref_model(o, a, b);
    accept(o, a, b);
    grants = 0;
    edge_due = -1;
    for (e = 1; e <= 400; e++) begin
      @(negedge clk);
      case (mode)
        0:       alu_gnt = 1'b1;
        1:       alu_gnt = e[0];
        default: alu_gnt = 1'($urandom_range(0, 1));
      endcase
      junk = $urandom;
      if (poke && e == 7) begin
        start = 1'b1; op = 2'b10; opa = $urandom; opb = 32'd1;
      end else begin
        start = 1'b0;
      end
      if (e == 1) begin
        check("aluctrl", 32'(alu_aluctrl), o[1] ? 32'(SUBU) : 32'(ADDU));
        check("alu_req", 32'(alu_req), 32'd1);
      end
      if (alu_gnt) grants++;
      if (grants == 32 && edge_due < 0) edge_due = e;
      @(posedge clk); #1;
      if (done) break;
    end
    alu_gnt = 1'b0;
    start = 1'b0;
    check("done_latency", 32'(e), 32'(edge_due));
    check("result", result, exp);
    check("busy_in_done", 32'(busy), 32'd0);
    held = result;
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 32'd0);
    check("result_held", result, held);
    check("idle_alu_ops", alu_r1 | alu_r2 | 32'(alu_aluctrl) | 32'(alu_alui), 32'd0);
  endtask

  // Abort after 'steps' granted steps, by flush or by async reset
  task automatic abort_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int steps, input bit use_rst);
    logic [31:0] prev;
    int dones;
    prev = result;
    accept(o, a, b);
    repeat (steps) begin
      @(negedge clk); alu_gnt = 1'b1;
      @(posedge clk); #1;
    end
    dones = 0;
    if (use_rst) begin
      #2 rst = 1'b1;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_alu_req", 32'(alu_req), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_alu_ops", alu_r1 | alu_r2 | 32'(alu_aluctrl) | 32'(alu_alui), 32'd0);
      @(negedge clk); rst = 1'b0; alu_gnt = 1'b0;
    end else begin
      @(negedge clk); flush = 1'b1; alu_gnt = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; alu_gnt = 1'b0;
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_result", result, prev);
      repeat (40) begin
        @(negedge clk); alu_gnt = 1'b1;
        @(posedge clk); #1;
        if (done) dones++;
      end
      alu_gnt = 1'b0;
      check("flush_no_done", 32'(dones), 32'd0);
      check("flush_result_kept", result, prev);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; alu_gnt = 1'b0;
    op = 2'b00; opa = '0; opb = '0; junk = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_alu_req", 32'(alu_req), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_alu_ops", alu_r1 | alu_r2 | 32'(alu_aluctrl) | 32'(alu_alui), 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op(2'b00, 32'd7, 32'd6, 0, 1'b0);
    check("mul_7x6", result, 32'h0000_002A);
    run_op(2'b01, 32'd7, 32'd6, 0, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    check("mulhu_max", result, 32'hFFFF_FFFE);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(2'b10, 32'd100, 32'd7, 0, 1'b0);
    check("divu_100_7", result, 32'd14);
    run_op(2'b11, 32'd100, 32'd7, 0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 0, 1'b0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 0, 1'b0);
    check("remu_big", result, 32'h7FFF_FFFE);
    run_op(2'b10, 32'd5, 32'd0, 0, 1'b0);
    run_op(2'b11, 32'd5, 32'd0, 0, 1'b0);
    check("remu_by_zero", result, 32'd5);
    run_op(2'b00, 32'd3, 32'd5, 1, 1'b1);
    check("mul_toggle", result, 32'd15);

    abort_op(2'b10, 32'hDEAD_BEEF, 32'd3, 9, 1'b0);
    run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0);
    abort_op(2'b10, 32'hDEAD_BEEF, 32'd3, 12, 1'b1);

    // start and flush together in IDLE: flush wins
    @(negedge clk); start = 1'b1; flush = 1'b1; op = 2'b00; opa = 32'd2; opb = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("start_flush_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'hFFFF_FFFF;
        3: b = {1'b1, 31'($urandom)};
        default: ;
      endcase
      run_op(2'($urandom_range(0, 3)), a, b, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
